// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the core datapath and pipeline_hazard_ctrl.
// The master side is the controller; the slave side is the datapath and caches.
interface pipeline_hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       dmem_req_MEM;
  logic [1:0] dcache_active;
  logic       branch_EX;
  logic       MemtoReg_EX;
  logic [4:0] wsel_EX;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       halt_WB;
  logic [1:0] ifid_ctrl;
  logic [1:0] idex_ctrl;
  logic [1:0] exmem_ctrl;
  logic [1:0] memwb_ctrl;
  logic       pc_en;

  modport master (
    input  ihit, dhit, dmem_req_MEM, dcache_active, branch_EX,
           MemtoReg_EX, wsel_EX, rs1_ID, rs2_ID, halt_WB,
    output ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl, pc_en
  );

  modport slave (
    output ihit, dhit, dmem_req_MEM, dcache_active, branch_EX,
           MemtoReg_EX, wsel_EX, rs1_ID, rs2_ID, halt_WB,
    input  ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl, pc_en
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Per-core pipeline sequencer: drives ADVANCE/STALL/FLUSH to the four pipeline registers,
// tracks data-memory wait time and keeps saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                  CLK,
  input  logic                  nRST,
  pipeline_hazard_ctrl_if.master hz,
  output logic                  halt,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] ADVANCE = 2'b00;
  localparam logic [1:0] STALL   = 2'b01;
  localparam logic [1:0] FLUSH   = 2'b10;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              memstall;
  logic              loaduse;
  logic              any_flush;
  logic [1:0]        ifid_c;
  logic [1:0]        idex_c;
  logic [1:0]        exmem_c;
  logic [1:0]        memwb_c;
  logic              pc_en_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_W'(MEM_TIMEOUT)) ? v : v + WAIT_W'(1);
  endfunction

  assign memstall = (hz.dmem_req_MEM & ~hz.dhit) | (hz.dcache_active != 2'b00);
  assign loaduse  = hz.MemtoReg_EX & (hz.wsel_EX != 5'd0) &
                    ((hz.wsel_EX == hz.rs1_ID) | (hz.wsel_EX == hz.rs2_ID));

  // Priority decode: older pipeline events win over younger ones.
  always_comb begin
    ifid_c     = ADVANCE;
    idex_c     = ADVANCE;
    exmem_c    = ADVANCE;
    memwb_c    = ADVANCE;
    pc_en_c    = 1'b1;
    next_state = RUN;
    if (!nRST) begin
      ifid_c  = FLUSH;
      idex_c  = FLUSH;
      exmem_c = FLUSH;
      memwb_c = FLUSH;
      pc_en_c = 1'b0;
    end else if (state == HALTED || hz.halt_WB) begin
      ifid_c     = STALL;
      idex_c     = STALL;
      exmem_c    = STALL;
      memwb_c    = STALL;
      pc_en_c    = 1'b0;
      next_state = HALTED;
    end else if (memstall) begin
      // EX is held here, so a pending redirect simply re-asserts after memory completes.
      ifid_c     = STALL;
      idex_c     = STALL;
      exmem_c    = STALL;
      memwb_c    = FLUSH;
      pc_en_c    = 1'b0;
      next_state = MEM_WAIT;
    end else if (hz.branch_EX) begin
      ifid_c = FLUSH;
      idex_c = FLUSH;
    end else if (loaduse) begin
      ifid_c  = STALL;
      idex_c  = FLUSH;
      pc_en_c = 1'b0;
    end else if (!hz.ihit) begin
      ifid_c  = FLUSH;
      pc_en_c = 1'b0;
    end
  end

  assign hz.ifid_ctrl  = ifid_c;
  assign hz.idex_ctrl  = idex_c;
  assign hz.exmem_ctrl = exmem_c;
  assign hz.memwb_ctrl = memwb_c;
  assign hz.pc_en      = pc_en_c;

  assign any_flush    = (ifid_c == FLUSH) | (idex_c == FLUSH) |
                        (exmem_c == FLUSH) | (memwb_c == FLUSH);
  assign wait_cnt_inc = wait_inc(wait_cnt);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= RUN;
      wait_cnt    <= '0;
      halt        <= 1'b0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (state != HALTED) begin
      state <= next_state;
      if (!pc_en_c) stall_cnt <= sat_inc(stall_cnt);
      if (any_flush) flush_cnt <= sat_inc(flush_cnt);
      if (next_state == HALTED) halt <= 1'b1;
      // Only cycles spent inside MEM_WAIT are counted; the entry cycle starts from zero.
      if (state == MEM_WAIT && next_state == MEM_WAIT) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == WAIT_W'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
      end else if (next_state != MEM_WAIT) begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a
// rule-based reference model of the hazard priorities, wait tracking and counters.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 6;
  localparam int MT    = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             nrst;
  logic             halt;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [8:0]       dut_out;

  int n_checks;
  int n_fail;

  // reference model state
  bit m_halted;
  bit m_in_wait;
  int m_wcnt;
  bit m_tmo;
  int m_stall;
  int m_flush;

  pipeline_hazard_ctrl_if hif();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .CLK(clk), .nRST(nrst), .hz(hif), .halt(halt), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign dut_out = {hif.ifid_ctrl, hif.idex_ctrl, hif.exmem_ctrl, hif.memwb_ctrl, hif.pc_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {ifid, idex, exmem, memwb, pc_en} from the priority rules.
  function automatic logic [8:0] model_out();
    bit ms, lu;
    if (!nrst) return 9'b10_10_10_10_0;
    if (m_halted) return 9'b01_01_01_01_0;
    ms = (hif.dmem_req_MEM && !hif.dhit) || (hif.dcache_active != 0);
    lu = hif.MemtoReg_EX && hif.wsel_EX != 0 &&
         (hif.wsel_EX == hif.rs1_ID || hif.wsel_EX == hif.rs2_ID);
    if (hif.halt_WB) return 9'b01_01_01_01_0;
    if (ms)            return 9'b01_01_01_10_0;
    if (hif.branch_EX) return 9'b10_10_00_00_1;
    if (lu)            return 9'b01_10_00_00_0;
    if (!hif.ihit)     return 9'b10_00_00_00_0;
    return 9'b00_00_00_00_1;
  endfunction

  task automatic model_edge(input logic [8:0] e);
    bit ms;
    if (!nrst) begin
      m_halted = 0; m_in_wait = 0; m_wcnt = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (!e[0] && m_stall < MAXC) m_stall++;
      if ((e[8:7] == 2'b10 || e[6:5] == 2'b10 || e[4:3] == 2'b10 || e[2:1] == 2'b10) &&
          m_flush < MAXC) m_flush++;
      ms = (hif.dmem_req_MEM && !hif.dhit) || (hif.dcache_active != 0);
      if (hif.halt_WB) begin
        m_halted = 1; m_in_wait = 0; m_wcnt = 0;
      end else if (ms) begin
        if (m_in_wait) begin
          if (m_wcnt < MT) m_wcnt++;
          if (m_wcnt == MT) m_tmo = 1;
        end
        m_in_wait = 1;
      end else begin
        m_in_wait = 0; m_wcnt = 0;
      end
    end
  endtask

  // Advance one clock: inputs are held from the negedge, model follows the rising edge.
  task automatic tick();
    logic [8:0] e;
    e = model_out();
    @(posedge clk);
    model_edge(e);
    @(negedge clk);
  endtask

  task automatic set_idle();
    hif.ihit = 1; hif.dhit = 0; hif.dmem_req_MEM = 0; hif.dcache_active = 0;
    hif.branch_EX = 0; hif.MemtoReg_EX = 0; hif.wsel_EX = 0; hif.rs1_ID = 0;
    hif.rs2_ID = 0; hif.halt_WB = 0;
  endtask

  task automatic do_reset();
    nrst = 0;
    set_idle();
    tick();
    tick();
    nrst = 1;
  endtask

  task automatic test_reset();
    nrst = 0;
    set_idle();
    #1;
    if (dut_out !== 9'b10_10_10_10_0) begin
      n_fail++; $display("FAIL reset_ctrl_async got=%b exp=%b", dut_out, 9'b10_10_10_10_0);
    end
    n_checks++;
    tick();
    tick();
    if (dut_out !== 9'b10_10_10_10_0) begin
      n_fail++; $display("FAIL reset_ctrl_held got=%b exp=%b", dut_out, 9'b10_10_10_10_0);
    end
    n_checks++;
    nrst = 1;
    #1;
    if (dut_out !== 9'b00_00_00_00_1) begin
      n_fail++; $display("FAIL reset_release_ctrl got=%b exp=%b", dut_out, 9'b00_00_00_00_1);
    end
    n_checks++;
    if ({halt, mem_timeout, stall_cnt, flush_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_state got halt=%b tmo=%b stall=%0d flush=%0d exp all 0",
                         halt, mem_timeout, stall_cnt, flush_cnt);
    end
    n_checks++;
  endtask

  task automatic test_load_use();
    do_reset();
    hif.MemtoReg_EX = 1; hif.wsel_EX = 5; hif.rs1_ID = 3; hif.rs2_ID = 5;
    #1;
    if (dut_out !== 9'b01_10_00_00_0) begin
      n_fail++; $display("FAIL loaduse_rs2 got=%b exp=%b", dut_out, 9'b01_10_00_00_0);
    end
    n_checks++;
    tick();
    hif.wsel_EX = 7; hif.rs1_ID = 7; hif.rs2_ID = 2;
    #1;
    if (dut_out !== 9'b01_10_00_00_0) begin
      n_fail++; $display("FAIL loaduse_rs1 got=%b exp=%b", dut_out, 9'b01_10_00_00_0);
    end
    n_checks++;
    tick();
    hif.wsel_EX = 0; hif.rs1_ID = 0; hif.rs2_ID = 0;
    #1;
    if (dut_out !== 9'b00_00_00_00_1) begin
      n_fail++; $display("FAIL loaduse_x0 got=%b exp=%b", dut_out, 9'b00_00_00_00_1);
    end
    n_checks++;
    tick();
    if (stall_cnt !== CNT_W'(2) || flush_cnt !== CNT_W'(2)) begin
      n_fail++; $display("FAIL loaduse_counters got stall=%0d flush=%0d exp 2/2", stall_cnt, flush_cnt);
    end
    n_checks++;
    set_idle();
  endtask

  task automatic test_dmiss();
    do_reset();
    hif.dmem_req_MEM = 1; hif.dhit = 0;
    for (int i = 0; i < 4; i++) begin
      hif.branch_EX = (i >= 2);
      #1;
      if (dut_out !== 9'b01_01_01_10_0) begin
        n_fail++; $display("FAIL dmiss_cycle%0d got=%b exp=%b", i, dut_out, 9'b01_01_01_10_0);
      end
      n_checks++;
      tick();
    end
    hif.branch_EX = 0; hif.dhit = 1;
    #1;
    if (dut_out !== 9'b00_00_00_00_1) begin
      n_fail++; $display("FAIL dmiss_done got=%b exp=%b", dut_out, 9'b00_00_00_00_1);
    end
    n_checks++;
    tick();
    if (stall_cnt !== CNT_W'(4) || flush_cnt !== CNT_W'(4)) begin
      n_fail++; $display("FAIL dmiss_counters got stall=%0d flush=%0d exp 4/4", stall_cnt, flush_cnt);
    end
    n_checks++;
    set_idle();
  endtask

  task automatic test_timeout();
    do_reset();
    hif.dcache_active = 2'b01;
    repeat (3) tick();
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early got=%b exp=0", mem_timeout);
    end
    n_checks++;
    repeat (7) tick();
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_set got=%b exp=1", mem_timeout);
    end
    n_checks++;
    hif.dcache_active = 2'b00;
    #1;
    if (dut_out !== 9'b00_00_00_00_1) begin
      n_fail++; $display("FAIL timeout_release_ctrl got=%b exp=%b", dut_out, 9'b00_00_00_00_1);
    end
    n_checks++;
    repeat (3) tick();
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout);
    end
    n_checks++;
  endtask

  task automatic test_halt_priority();
    do_reset();
    hif.halt_WB = 1; hif.branch_EX = 1; hif.dmem_req_MEM = 1; hif.dhit = 0;
    #1;
    if (dut_out !== 9'b01_01_01_01_0) begin
      n_fail++; $display("FAIL halt_priority got=%b exp=%b", dut_out, 9'b01_01_01_01_0);
    end
    n_checks++;
    if (halt !== 1'b0) begin
      n_fail++; $display("FAIL halt_not_yet got=%b exp=0", halt);
    end
    n_checks++;
    tick();
    if (halt !== 1'b1 || stall_cnt !== CNT_W'(1) || flush_cnt !== CNT_W'(0)) begin
      n_fail++; $display("FAIL halt_entry got halt=%b stall=%0d flush=%0d exp 1/1/0",
                         halt, stall_cnt, flush_cnt);
    end
    n_checks++;
    for (int i = 0; i < 20; i++) begin
      hif.ihit = 1'($urandom); hif.dhit = 1'($urandom); hif.dmem_req_MEM = 1'($urandom);
      hif.dcache_active = 2'($urandom); hif.branch_EX = 1'($urandom);
      hif.MemtoReg_EX = 1'($urandom); hif.wsel_EX = 5'($urandom_range(0, 3));
      hif.rs1_ID = 5'($urandom_range(0, 3)); hif.rs2_ID = 5'($urandom_range(0, 3));
      hif.halt_WB = 1'($urandom);
      #1;
      if (dut_out !== 9'b01_01_01_01_0) begin
        n_fail++; $display("FAIL halted_ctrl cyc=%0d got=%b exp=%b", i, dut_out, 9'b01_01_01_01_0);
      end
      n_checks++;
      tick();
      if (halt !== 1'b1 || stall_cnt !== CNT_W'(1) || flush_cnt !== CNT_W'(0)) begin
        n_fail++; $display("FAIL halted_frozen cyc=%0d got halt=%b stall=%0d flush=%0d exp 1/1/0",
                           i, halt, stall_cnt, flush_cnt);
      end
      n_checks++;
    end
    set_idle();
  endtask

  task automatic test_branch();
    do_reset();
    hif.branch_EX = 1; hif.ihit = 0; hif.MemtoReg_EX = 1; hif.wsel_EX = 4; hif.rs1_ID = 4;
    #1;
    if (dut_out !== 9'b10_10_00_00_1) begin
      n_fail++; $display("FAIL branch_ctrl got=%b exp=%b", dut_out, 9'b10_10_00_00_1);
    end
    n_checks++;
    tick();
    if (flush_cnt !== CNT_W'(1) || stall_cnt !== CNT_W'(0)) begin
      n_fail++; $display("FAIL branch_counters got flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt);
    end
    n_checks++;
    set_idle();
    hif.ihit = 0;
    #1;
    if (dut_out !== 9'b10_00_00_00_0) begin
      n_fail++; $display("FAIL imiss_ctrl got=%b exp=%b", dut_out, 9'b10_00_00_00_0);
    end
    n_checks++;
    tick();
    set_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    hif.ihit = 0;
    repeat (MAXC + 8) tick();
    if (stall_cnt !== CNT_W'(MAXC) || flush_cnt !== CNT_W'(MAXC)) begin
      n_fail++; $display("FAIL counter_saturate got stall=%0d flush=%0d exp %0d/%0d",
                         stall_cnt, flush_cnt, MAXC, MAXC);
    end
    n_checks++;
    set_idle();
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        nrst = ($urandom_range(0, 59) != 0);
        hif.ihit = ($urandom_range(0, 7) != 0);
        hif.dhit = ($urandom_range(0, 2) == 0);
        hif.dmem_req_MEM = ($urandom_range(0, 3) == 0);
        hif.dcache_active = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        hif.branch_EX = ($urandom_range(0, 6) == 0);
        hif.MemtoReg_EX = 1'($urandom);
        hif.wsel_EX = 5'($urandom_range(0, 3));
        hif.rs1_ID = 5'($urandom_range(0, 3));
        hif.rs2_ID = 5'($urandom_range(0, 3));
        hif.halt_WB = ($urandom_range(0, 299) == 0);
        #1;
        e = model_out();
        if (dut_out !== e) begin
          n_fail++; $display("FAIL rand_ctrl blk=%0d cyc=%0d got=%b exp=%b", blk, i, dut_out, e);
        end
        n_checks++;
        tick();
        if (halt !== m_halted || mem_timeout !== m_tmo ||
            stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
          n_fail++;
          $display("FAIL rand_state blk=%0d cyc=%0d got halt=%b tmo=%b stall=%0d flush=%0d exp %0b/%0b/%0d/%0d",
                   blk, i, halt, mem_timeout, stall_cnt, flush_cnt, m_halted, m_tmo, m_stall, m_flush);
        end
        n_checks++;
      end
    end
    nrst = 1;
    set_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nrst     = 0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_dmiss();
    test_timeout();
    test_halt_priority();
    test_branch();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
